// File: rtl/evt_write_sched_if.sv
// rtl/evt_write_sched_if.sv - request, event and commit signals of the event-scheduled write unit
interface evt_write_sched_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [CNT_W-1:0] req_cnt0;
  logic [CNT_W-1:0] req_cnt1;
  logic             evt;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             q_upd;
  logic [1:0]       done;
  logic             aborted;
  logic             busy;
  logic             grant_id;

  modport master (
    output req_valid, req_data0, req_data1, req_cnt0, req_cnt1, evt, abort,
    input  req_ready, q, q_upd, done, aborted, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data0, req_data1, req_cnt0, req_cnt1, evt, abort,
    output req_ready, q, q_upd, done, aborted, busy, grant_id
  );
endinterface

// File: rtl/evt_write_sched.sv
// rtl/evt_write_sched.sv - two-requester write scheduler committing after N event strobes
// Round-robin accept in IDLE, count events in WAIT, publish the value in COMMIT.
module evt_write_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  evt_write_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] q_r;
  logic [CNT_W-1:0] remaining;
  logic             last_served;
  logic             grant_r;
  logic             q_upd_r;
  logic [1:0]       done_r;
  logic             aborted_r;
  logic             busy_r;

  logic             pick;
  logic [1:0]       ready;
  logic [WIDTH-1:0] data_sel;
  logic [CNT_W-1:0] cnt_sel;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (bus.req_valid == 2'b11)
      pick = ~last_served;
    else if (bus.req_valid[1])
      pick = 1'b1;
    ready = 2'b00;
    if (rst_n && (state == IDLE) && (|bus.req_valid))
      ready[pick] = 1'b1;
    data_sel = pick ? bus.req_data1 : bus.req_data0;
    cnt_sel  = pick ? bus.req_cnt1  : bus.req_cnt0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      data_r      <= '0;
      q_r         <= '0;
      remaining   <= '0;
      last_served <= 1'b1;
      grant_r     <= 1'b0;
      q_upd_r     <= 1'b0;
      done_r      <= 2'b00;
      aborted_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      q_upd_r   <= 1'b0;
      done_r    <= 2'b00;
      aborted_r <= 1'b0;
      case (state)
        IDLE: begin
          if (|ready) begin
            grant_r <= pick;
            data_r  <= data_sel;
            busy_r  <= 1'b1;
            if (cnt_sel == '0) begin
              state     <= COMMIT;
              remaining <= '0;
            end else begin
              state     <= WAIT;
              remaining <= cnt_sel;
            end
          end
        end
        WAIT: begin
          // Abort takes priority over a final event arriving in the same cycle.
          if (bus.abort) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            aborted_r   <= 1'b1;
            last_served <= grant_r;
            remaining   <= '0;
          end else if (bus.evt) begin
            if (remaining == CNT_W'(1)) begin
              state     <= COMMIT;
              remaining <= '0;
            end else begin
              remaining <= remaining - CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          q_r         <= data_r;
          q_upd_r     <= 1'b1;
          done_r      <= grant_r ? 2'b10 : 2'b01;
          last_served <= grant_r;
          state       <= IDLE;
          busy_r      <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.q         = q_r;
  assign bus.q_upd     = q_upd_r;
  assign bus.done      = done_r;
  assign bus.aborted   = aborted_r;
  assign bus.busy      = busy_r;
  assign bus.grant_id  = grant_r;
endmodule

// File: tb/tb_evt_write_sched.sv
// tb/tb_evt_write_sched.sv - directed bench with commit/abort scoreboard for evt_write_sched
module tb_evt_write_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  evt_write_sched_if ifc ();
  evt_write_sched dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  typedef struct packed {
    logic [7:0] q;
    logic [1:0] done;
  } commit_t;

  commit_t exp_q[$];
  int      abort_q[$];
  int      compared = 0;
  int      mismatched = 0;
  int      w;

  function automatic void check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  // Monitor: every commit or abort the DUT reports is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.q_upd) begin
        if (exp_q.size() == 0) check("unexpected_q_upd", 1, 0);
        else begin
          commit_t e;
          e = exp_q.pop_front();
          check("commit_q", ifc.q, e.q);
          check("commit_done", ifc.done, e.done);
        end
      end else if (ifc.done != 2'b00) begin
        check("done_without_q_upd", ifc.done, 0);
      end
      if (ifc.aborted) begin
        if (abort_q.size() == 0) check("unexpected_aborted", 1, 0);
        else begin
          int hold;
          hold = abort_q.pop_front();
          check("aborted_q_hold", ifc.q, hold);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string name, input logic exp_grant, output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((ifc.req_valid & ifc.req_ready) != 2'b00) begin
        got = 1'b1;
        check({name, "_ready"}, ifc.req_ready, exp_grant ? 2 : 1);
        tick();
        check({name, "_grant_id"}, ifc.grant_id, exp_grant);
      end else begin
        waits++;
      end
    end
    if (!got) check({name, "_accept_timeout"}, 0, 1);
  endtask

  task automatic pulse_evt(input int n);
    repeat (n) begin
      ifc.evt = 1'b1;
      tick();
      ifc.evt = 1'b0;
      tick();
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 50 && !idle; i++) begin
      tick();
      if (!ifc.busy) idle = 1'b1;
    end
    if (!idle) check({name, "_idle_timeout"}, 0, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.req_valid = 2'b11;
    ifc.req_data0 = 8'h11;
    ifc.req_data1 = 8'h22;
    ifc.req_cnt0  = 4'd0;
    ifc.req_cnt1  = 4'd0;
    ifc.evt       = 1'b0;
    ifc.abort     = 1'b0;
    #2 rst_n = 1'b0;
    #21;
    check("rst_q", ifc.q, 0);
    check("rst_q_upd", ifc.q_upd, 0);
    check("rst_done", ifc.done, 0);
    check("rst_aborted", ifc.aborted, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_grant_id", ifc.grant_id, 0);
    check("rst_req_ready", ifc.req_ready, 0);
    tick();
    rst_n = 1'b1;

    // Tie after reset: req0 first, then req1 after exactly one idle cycle.
    exp_q.push_back('{q: 8'h11, done: 2'b01});
    exp_q.push_back('{q: 8'h22, done: 2'b10});
    wait_accept("t1_first", 1'b0, w);
    check("t1_first_wait", w, 0);
    ifc.req_valid = 2'b10;
    @(negedge clk);
    check("t1_commit_ready", ifc.req_ready, 0);
    check("t1_commit_busy", ifc.busy, 1);
    check("t1_commit_q_upd", ifc.q_upd, 0);
    @(negedge clk);
    check("t1_first_q_upd", ifc.q_upd, 1);
    check("t1_idle_ready", ifc.req_ready, 2);
    tick();
    check("t1_second_grant", ifc.grant_id, 1);
    ifc.req_valid = 2'b00;
    wait_idle("t1");

    // cnt=2 with an event in the accept cycle that must not count.
    ifc.req_data0 = 8'hA5;
    ifc.req_cnt0  = 4'd2;
    ifc.req_valid = 2'b01;
    ifc.evt       = 1'b1;
    exp_q.push_back('{q: 8'hA5, done: 2'b01});
    wait_accept("t2", 1'b0, w);
    ifc.evt       = 1'b0;
    ifc.req_valid = 2'b00;
    tick();
    pulse_evt(1);
    check("t2_after_evt1_busy", ifc.busy, 1);
    check("t2_after_evt1_q_upd", ifc.q_upd, 0);
    ifc.evt = 1'b1;
    tick();
    ifc.evt = 1'b0;
    check("t2_commit_q_upd", ifc.q_upd, 0);
    check("t2_commit_busy", ifc.busy, 1);
    tick();
    check("t2_q_upd", ifc.q_upd, 1);
    check("t2_q", ifc.q, 8'hA5);
    check("t2_busy_after", ifc.busy, 0);
    tick();

    // cnt=3, abort arrives with the final event and wins.
    ifc.req_data1 = 8'h33;
    ifc.req_cnt1  = 4'd3;
    ifc.req_valid = 2'b10;
    wait_accept("t3", 1'b1, w);
    ifc.req_valid = 2'b00;
    pulse_evt(2);
    check("t3_pending_busy", ifc.busy, 1);
    ifc.evt   = 1'b1;
    ifc.abort = 1'b1;
    abort_q.push_back(8'hA5);
    tick();
    ifc.evt   = 1'b0;
    ifc.abort = 1'b0;
    check("t3_aborted", ifc.aborted, 1);
    check("t3_busy", ifc.busy, 0);
    check("t3_q", ifc.q, 8'hA5);
    check("t3_q_upd", ifc.q_upd, 0);
    tick();
    check("t3_aborted_pulse_end", ifc.aborted, 0);
    check("t3_done", ifc.done, 0);

    // Reset in the middle of WAIT discards the pending write.
    ifc.req_data0 = 8'h44;
    ifc.req_cnt0  = 4'd5;
    ifc.req_valid = 2'b01;
    wait_accept("t4", 1'b0, w);
    ifc.req_valid = 2'b00;
    pulse_evt(2);
    rst_n = 1'b0;
    ifc.req_valid = 2'b11;
    #1;
    check("t4_rst_q", ifc.q, 0);
    check("t4_rst_busy", ifc.busy, 0);
    check("t4_rst_ready", ifc.req_ready, 0);
    ifc.req_data0 = 8'h55;
    ifc.req_cnt0  = 4'd0;
    ifc.req_data1 = 8'h66;
    ifc.req_cnt1  = 4'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    exp_q.push_back('{q: 8'h55, done: 2'b01});
    wait_accept("t4_tie", 1'b0, w);
    ifc.req_valid = 2'b00;
    wait_idle("t4");

    // Both requesters valid continuously, abort held high: grants alternate and commits complete.
    ifc.req_data0 = 8'h88;
    ifc.req_data1 = 8'h77;
    ifc.abort     = 1'b1;
    ifc.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2 == 0) ? 1'b1 : 1'b0;
      exp_q.push_back('{q: g ? 8'h77 : 8'h88, done: g ? 2'b10 : 2'b01});
      wait_accept("t5", g, w);
    end
    ifc.req_valid = 2'b00;
    wait_idle("t5");
    ifc.abort = 1'b0;
    repeat (3) tick();

    check("scoreboard_commits_left", exp_q.size(), 0);
    check("scoreboard_aborts_left", abort_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
